// File: rtl/jpeg_pipe_sequencer.sv
// jpeg_pipe_sequencer
//   Start-triggered sequencer for the JPEG encode pipeline. A single
//   stall-able 16-bit timebase `t` drives every decode: the input SRAM row
//   walk, the DCT/quantizer row indices, the two transpose ping-pong
//   selects, the RLE clock enable and the output-memory write stream.
//
//   Optional feature macro: JPEG_SEQ_AUTORESTART_EN
//     defined   -> `start` seen in the DONE cycle goes straight back to RUN
//     undefined -> DONE always returns to IDLE
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   start               run request, only looked at in IDLE (and DONE with
//                       autorestart)
//   stall               freezes the timebase and gates all strobes
//   busy, done          RUN/DRAIN indicator, one-cycle completion pulse
//   mem_rd_en, mem_addr input SRAM read strobe / row address
//   row_idx, qt_row     DCT row index, quantizer row (row_idx - 2)
//   tp1_sel, tp2_sel    transpose-1 and zigzag-transpose ping-pong selects
//   rle_en              RLE stage clock enable
//   out_wr_en, out_addr output SRAM write strobe / row address

module jpeg_pipe_sequencer #(
    parameter int unsigned NUM_BLOCKS = 4096,
    parameter int unsigned ZZ_OFS     = 9,
    parameter int unsigned RLE_OFS    = 18,
    parameter int unsigned OUT_OFS    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic        mem_rd_en,
    output logic [14:0] mem_addr,
    output logic [2:0]  row_idx,
    output logic [2:0]  qt_row,
    output logic        tp1_sel,
    output logic        tp2_sel,
    output logic        rle_en,
    output logic        out_wr_en,
    output logic [14:0] out_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Timebase landmarks. All fit in 16 bits even for 4096 blocks
    // (last drain value 32794), so compares are done at full width.
    localparam logic [15:0] T_LAST    = 16'(8 * NUM_BLOCKS - 1);
    localparam logic [15:0] DRAIN_END = 16'(8 * NUM_BLOCKS - 1 + OUT_OFS);
    localparam logic [15:0] ZZ_T      = 16'(ZZ_OFS);
    localparam logic [3:0]  ZZ_LO     = 4'(ZZ_OFS);
    localparam logic [15:0] RLE_LO    = 16'(RLE_OFS);
    localparam logic [15:0] RLE_HI    = 16'(8 * NUM_BLOCKS - 1 + RLE_OFS);
    localparam logic [15:0] OUT_LO    = 16'(OUT_OFS);
    localparam logic [14:0] OUT_LO15  = 15'(OUT_OFS);

    logic [1:0]  state;
    logic [15:0] t;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        t     <= '0;
                    end
                end
                S_RUN: begin
                    // A stalled cycle never transitions; the move to DRAIN
                    // happens on the first advancing edge at T-1.
                    if (!stall) begin
                        t <= t + 16'd1;
                        if (t == T_LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        t <= t + 16'd1;
                        if (t == DRAIN_END) state <= S_DONE;
                    end
                end
                S_DONE: begin
`ifdef JPEG_SEQ_AUTORESTART_EN
                    if (start) begin
                        state <= S_RUN;
                        t     <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decodes, all combinational from registered state/t
    // ------------------------------------------------------------------
    logic       active;
    logic       adv;
    logic       rle_win;
    logic       out_win;
    logic [3:0] zz_lo;

    always_comb begin
        active  = (state == S_RUN) || (state == S_DRAIN);
        adv     = active && !stall;
        rle_win = (t >= RLE_LO) && (t <= RLE_HI);
        out_win = (t >= OUT_LO) && (t <= DRAIN_END);
        // Only bit 3 of (t - ZZ_OFS) matters, so the low nibble is enough.
        zz_lo   = t[3:0] - ZZ_LO;
    end

    always_comb begin
        busy      = active;
        done      = (state == S_DONE);
        mem_rd_en = adv && (state == S_RUN);
        mem_addr  = (state == S_RUN) ? t[14:0] : 15'd0;

        // Index/select outputs sit at their reset values outside RUN/DRAIN
        // so IDLE and DONE look identical to the post-reset state.
        row_idx   = active ? t[2:0] : 3'd0;
        qt_row    = active ? (t[2:0] - 3'd2) : 3'd0;
        tp1_sel   = active ? ~t[3] : 1'b1;
        tp2_sel   = (!active || (t < ZZ_T)) ? 1'b1 : (zz_lo < 4'd8);

        rle_en    = adv && rle_win;
        out_wr_en = adv && out_win;
        // Address tracks the window regardless of stall, so it holds its
        // value through a stalled write slot just as mem_addr does.
        out_addr  = (active && out_win) ? (t[14:0] - OUT_LO15) : 15'd0;
    end

endmodule

// File: doc/jpeg_pipe_sequencer.md
# jpeg_pipe_sequencer

Start-triggered sequencer for the JPEG encode pipeline. It replaces the free-running row counter and transpose-control logic. On `start` it walks the input SRAM one 8-pixel row per cycle, for `NUM_BLOCKS` 8×8 blocks. From a single stall-able timebase it generates the DCT row index, quantizer row index, the two ping-pong transpose selects, the RLE clock enable and the output-memory write strobe/address. It raises `done` once the last output row has been written, then returns to idle.

## Interface
- `NUM_BLOCKS`, 4096, number of 8×8 blocks per run (1..4096); total rows T = 8·NUM_BLOCKS
- `ZZ_OFS`, 9, timebase offset at which the zigzag/transpose-2 ping-pong starts
- `RLE_OFS`, 18, timebase offset of the first RLE-enabled cycle
- `OUT_OFS`, 27, timebase offset of the first output-memory write
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; one clock, reset is asynchronous and active-high
- `start` in 1: run request, sampled only in IDLE
- `stall` in 1: back-pressure; freezes the timebase while high
- `busy` out 1: high in RUN and DRAIN
- `done` out 1: one-cycle pulse in DONE
- `mem_rd_en` out 1: input SRAM read strobe
- `mem_addr` out 15: input SRAM row address
- `row_idx` out 3: DCT second-pass coefficient row
- `qt_row` out 3: quantizer row (row_idx delayed by 2)
- `tp1_sel` out 1: transpose-1 ping-pong select
- `tp2_sel` out 1: zigzag-transpose ping-pong select
- `rle_en` out 1: RLE stage clock enable
- `out_wr_en` out 1: output SRAM write strobe
- `out_addr` out 15: output SRAM row address

## Operation
- 16-bit timebase `t`. It advances by 1 on each clock in RUN/DRAIN with `stall`=0 and holds while `stall`=1. It clears to 0 on entry to RUN.
- States:
  - IDLE: leave on `start`=1, go to RUN.
  - RUN: go to DRAIN on the advancing edge where t = T−1.
  - DRAIN: go to DONE on the advancing edge where t = T−1+OUT_OFS.
  - DONE: go to IDLE after 1 cycle.
- Decodes are combinational from registered `t`/state. All strobes are forced to 0 whenever `stall`=1 or the state is IDLE/DONE.
  - `mem_rd_en` = RUN. `mem_addr` = t[14:0] in RUN, 0 otherwise.
  - `row_idx` = t[2:0]. `qt_row` = (t−2)[2:0], modulo 8.
  - `tp1_sel` = ~t[3]. It is 1 for block 0 and toggles every 8 advances.
  - `tp2_sel` = 1 for t < ZZ_OFS, and ~((t−ZZ_OFS)>>3)[0] otherwise.
  - `rle_en` = 1 for RLE_OFS ≤ t ≤ T−1+RLE_OFS.
  - `out_wr_en` = 1 for OUT_OFS ≤ t ≤ T−1+OUT_OFS. `out_addr` = (t−OUT_OFS)[14:0] while writing, 0 otherwise.
- `start` in RUN, DRAIN or DONE is ignored. `stall` in IDLE is ignored.
- If `stall` and the RUN→DRAIN or DRAIN→DONE condition coincide, the transition waits for the first non-stalled cycle.
- NUM_BLOCKS=4096 gives the full address range 0..32767 with no wrap. The t compare uses the full 16 bits.

## Timing
- Reset (async assert): state=IDLE, t=0. Outputs: busy=0, done=0, mem_rd_en=0, mem_addr=0, row_idx=0, qt_row=0, tp1_sel=1, tp2_sel=1, rle_en=0, out_wr_en=0, out_addr=0.
- Reset asserted mid-run aborts immediately, with no `done`. Deassertion is synchronised externally.
- Start latency: `start` sampled at edge k gives busy=1, mem_rd_en=1, mem_addr=0 in the cycle after edge k.
- Run length without stall: T+OUT_OFS cycles of busy, then exactly 1 cycle of done.
- The earliest next `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `JPEG_SEQ_AUTORESTART_EN`
  - Defined: if `start`=1 during the DONE cycle, the next state is RUN with t=0, without passing through IDLE. `done` still pulses for 1 cycle.
  - Undefined: DONE always goes to IDLE, and `start` in DONE is ignored.

## Test plan
- Reset with `start`=1 held, then release → all outputs at their reset values. The run begins only after reset deasserts.
- NUM_BLOCKS=2, single `start` pulse, no stall:
  - mem_addr steps 0..15 over 16 cycles.
  - tp1_sel = 1 for rows 0–7 and 0 for rows 8–15.
  - rle_en is high for t=18..33.
  - out_wr_en is high for t=27..42 with out_addr 0..15.
  - done is high exactly 44 cycles after the start edge.
- Same run with `stall`=1 for 3 cycles at t=5 and for 2 cycles at t=42:
  - All strobes are 0 during the stalls and mem_addr holds at 5.
  - done is delayed by exactly 5 cycles.
  - The sequence of out_addr values is unchanged.
- `start` re-pulsed at t=3 and t=30 → ignored. The run completes with a single done.
- `reset` asserted at t=20 → next cycle busy=0 and rle_en=0, with no done pulse. A fresh `start` then runs from mem_addr=0.
- With `JPEG_SEQ_AUTORESTART_EN` and `start` held high:
  - done pulses once.
  - The next cycle has busy=1 and mem_addr=0.
  - tp2_sel is 1 again for t < 9.
